draw_rect: RTL and testbench

Downstream stage of `draw_rct_ctl`. Consumes its `xpos`/`ypos` rectangle position and overlays a bitmap rectangle onto the incoming VGA timing/RGB stream. It generates the image-ROM read address and merges the returned pixel. All timing signals are delayed to match, so the output stream is aligned. The output feeds the final VGA output register.

---
 rtl/vga_pkg.sv | 18 +
 rtl/draw_rect_addr.sv | 42 ++++
 rtl/draw_rect.sv | 158 +++++++++++++++
 tb/tb_draw_rect.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// +----------------------------------------------------------------------------+
// | vga_pkg                                                                    |
// | Shared VGA constants and types for the 1024x768 display pipeline.          |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

package vga_pkg;

  localparam int HOR_PIXELS = 1024;
  localparam int VER_PIXELS = 768;
  localparam int POS_W      = 12;

  typedef logic [11:0] rgb_t;

endpackage

`default_nettype wire

// File: rtl/draw_rect_addr.sv
// +----------------------------------------------------------------------------+
// | draw_rect_addr                                                             |
// | Combinational in-rectangle test and image-ROM address for one pixel.       |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module draw_rect_addr
  import vga_pkg::*;
#(
  parameter int RECT_W = 48,
  parameter int RECT_H = 64
) (
  input  logic [10:0]      hcount_i,
  input  logic [10:0]      vcount_i,
  input  logic             hblnk_i,
  input  logic             vblnk_i,
  input  logic [POS_W-1:0] px_i,
  input  logic [POS_W-1:0] py_i,
  output logic             inside_o,
  output logic [11:0]      addr_o
);

  logic [12:0] w_dx;
  logic [12:0] w_dy;
  logic        w_in_x;
  logic        w_in_y;

  // 13-bit differences: bit 12 set means the pixel lies left of / above the
  // rectangle, so a large position can never wrap back onto the screen.
  assign w_dx = {2'b00, hcount_i} - {1'b0, px_i};
  assign w_dy = {2'b00, vcount_i} - {1'b0, py_i};

  assign w_in_x = ~w_dx[12] && (w_dx[11:0] < 12'(RECT_W));
  assign w_in_y = ~w_dy[12] && (w_dy[11:0] < 12'(RECT_H));

  assign inside_o = w_in_x && w_in_y && ~hblnk_i && ~vblnk_i;
  assign addr_o   = {w_dy[5:0], w_dx[5:0]};

endmodule

`default_nettype wire

// File: rtl/draw_rect.sv
// +----------------------------------------------------------------------------+
// | draw_rect                                                                  |
// | Overlays a ROM bitmap rectangle on the VGA stream with 2-cycle latency.    |
// | Optional macro DRAW_RECT_FRAME_LATCH_EN: latch xpos/ypos at frame start.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module draw_rect
  import vga_pkg::*;
#(
  parameter int RECT_W = 48,
  parameter int RECT_H = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [POS_W-1:0] xpos,
  input  logic [POS_W-1:0] ypos,
  input  logic [10:0]      hcount_in,
  input  logic [10:0]      vcount_in,
  input  logic             hsync_in,
  input  logic             vsync_in,
  input  logic             hblnk_in,
  input  logic             vblnk_in,
  input  rgb_t             rgb_in,
  output logic [11:0]      pixel_addr,
  input  rgb_t             rgb_pixel,
  output logic [10:0]      hcount_out,
  output logic [10:0]      vcount_out,
  output logic             hsync_out,
  output logic             vsync_out,
  output logic             hblnk_out,
  output logic             vblnk_out,
  output rgb_t             rgb_out
);

  logic [POS_W-1:0] w_px;
  logic [POS_W-1:0] w_py;
  logic             w_inside;
  logic [11:0]      w_addr;

`ifdef DRAW_RECT_FRAME_LATCH_EN
  logic [POS_W-1:0] px_q;
  logic [POS_W-1:0] py_q;

  // The frame-start pixel itself still compares against the previous value.
  always_ff @(posedge clk) begin
    if (rst) begin
      px_q <= '0;
      py_q <= '0;
    end else if (hcount_in == 11'd0 && vcount_in == 11'd0) begin
      px_q <= xpos;
      py_q <= ypos;
    end
  end

  assign w_px = px_q;
  assign w_py = py_q;
`else
  assign w_px = xpos;
  assign w_py = ypos;
`endif

  draw_rect_addr #(
    .RECT_W (RECT_W),
    .RECT_H (RECT_H)
  ) u_addr (
    .hcount_i (hcount_in),
    .vcount_i (vcount_in),
    .hblnk_i  (hblnk_in),
    .vblnk_i  (vblnk_in),
    .px_i     (w_px),
    .py_i     (w_py),
    .inside_o (w_inside),
    .addr_o   (w_addr)
  );

  logic [10:0] hcount_s1_q;
  logic [10:0] vcount_s1_q;
  logic        hsync_s1_q;
  logic        vsync_s1_q;
  logic        hblnk_s1_q;
  logic        vblnk_s1_q;
  rgb_t        rgb_s1_q;
  logic        inside_s1_q;
  logic [11:0] pixel_addr_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_s1_q  <= '0;
      vcount_s1_q  <= '0;
      hsync_s1_q   <= 1'b0;
      vsync_s1_q   <= 1'b0;
      hblnk_s1_q   <= 1'b0;
      vblnk_s1_q   <= 1'b0;
      rgb_s1_q     <= '0;
      inside_s1_q  <= 1'b0;
      pixel_addr_q <= '0;
    end else begin
      hcount_s1_q  <= hcount_in;
      vcount_s1_q  <= vcount_in;
      hsync_s1_q   <= hsync_in;
      vsync_s1_q   <= vsync_in;
      hblnk_s1_q   <= hblnk_in;
      vblnk_s1_q   <= vblnk_in;
      rgb_s1_q     <= rgb_in;
      inside_s1_q  <= w_inside;
      pixel_addr_q <= w_addr;
    end
  end

  assign pixel_addr = pixel_addr_q;

  logic [10:0] hcount_s2_q;
  logic [10:0] vcount_s2_q;
  logic        hsync_s2_q;
  logic        vsync_s2_q;
  logic        hblnk_s2_q;
  logic        vblnk_s2_q;
  rgb_t        rgb_s2_q;
  logic        inside_s2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_s2_q <= '0;
      vcount_s2_q <= '0;
      hsync_s2_q  <= 1'b0;
      vsync_s2_q  <= 1'b0;
      hblnk_s2_q  <= 1'b0;
      vblnk_s2_q  <= 1'b0;
      rgb_s2_q    <= '0;
      inside_s2_q <= 1'b0;
    end else begin
      hcount_s2_q <= hcount_s1_q;
      vcount_s2_q <= vcount_s1_q;
      hsync_s2_q  <= hsync_s1_q;
      vsync_s2_q  <= vsync_s1_q;
      hblnk_s2_q  <= hblnk_s1_q;
      vblnk_s2_q  <= vblnk_s1_q;
      rgb_s2_q    <= rgb_s1_q;
      inside_s2_q <= inside_s1_q;
    end
  end

  assign hcount_out = hcount_s2_q;
  assign vcount_out = vcount_s2_q;
  assign hsync_out  = hsync_s2_q;
  assign vsync_out  = vsync_s2_q;
  assign hblnk_out  = hblnk_s2_q;
  assign vblnk_out  = vblnk_s2_q;

  // The registered ROM delivers its word in the same cycle the stage-2
  // registers present it, so the merge is a plain mux on the ROM output.
  assign rgb_out = inside_s2_q ? rgb_pixel : rgb_s2_q;

endmodule

`default_nettype wire

// File: tb/tb_draw_rect.sv
// +----------------------------------------------------------------------------+
// | tb_draw_rect                                                               |
// | Directed self-checking bench for draw_rect with a registered ROM model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_draw_rect;

  localparam int RW = 48;
  localparam int RH = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] xpos, ypos;
  logic [10:0] hcount_in, vcount_in;
  logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
  logic [11:0] rgb_in;
  logic [11:0] pixel_addr;
  logic [11:0] rgb_pixel;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [11:0] rgb_out;

  typedef struct packed {
    logic [25:0] t;
    logic [11:0] r;
  } exp_t;

  exp_t q[$];
  int   lx, ly;
  int   n_total = 0;
  int   n_pass  = 0;

  always #5 clk = ~clk;

  // Image ROM model: one-cycle registered read returning the address itself.
  always @(posedge clk) rgb_pixel <= pixel_addr;

  draw_rect #(
    .RECT_W (RW),
    .RECT_H (RH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .xpos       (xpos),
    .ypos       (ypos),
    .hcount_in  (hcount_in),
    .vcount_in  (vcount_in),
    .hsync_in   (hsync_in),
    .vsync_in   (vsync_in),
    .hblnk_in   (hblnk_in),
    .vblnk_in   (vblnk_in),
    .rgb_in     (rgb_in),
    .pixel_addr (pixel_addr),
    .rgb_pixel  (rgb_pixel),
    .hcount_out (hcount_out),
    .vcount_out (vcount_out),
    .hsync_out  (hsync_out),
    .vsync_out  (vsync_out),
    .hblnk_out  (hblnk_out),
    .vblnk_out  (vblnk_out),
    .rgb_out    (rgb_out)
  );

  // Drive one pixel, advance one clock, and hand back the expectation for
  // the pixel now visible at the outputs (driven two edges earlier).
  task automatic step(input int h, input int v, output bit have, output exp_t e);
    int          px, py;
    bit          hb, vb, ins;
    logic [11:0] bg;
    exp_t        cur;
    hb = (h >= 1024);
    vb = (v >= 768);
    bg = 12'((h * 7) ^ (v * 13));
`ifdef DRAW_RECT_FRAME_LATCH_EN
    px = lx;
    py = ly;
    if (h == 0 && v == 0) begin
      lx = int'(xpos);
      ly = int'(ypos);
    end
`else
    px = int'(xpos);
    py = int'(ypos);
`endif
    ins = (h >= px) && (h < px + RW) && (v >= py) && (v < py + RH) && !hb && !vb;
    hcount_in = 11'(h);
    vcount_in = 11'(v);
    hsync_in  = (h >= 1048 && h < 1184);
    vsync_in  = (v >= 771 && v < 777);
    hblnk_in  = hb;
    vblnk_in  = vb;
    rgb_in    = bg;
    cur.t = {11'(h), 11'(v), hsync_in, vsync_in, hb, vb};
    cur.r = ins ? {6'(v - py), 6'(h - px)} : bg;
    q.push_back(cur);
    @(posedge clk);
    #1;
    have = 1'b0;
    e    = '0;
    if (q.size() >= 2) begin
      e    = q.pop_front();
      have = 1'b1;
    end
  endtask

  task automatic test_reset();
    bit   have;
    exp_t e;
    rst  = 1'b1;
    xpos = 12'd100;
    ypos = 12'd200;
    for (int i = 0; i < 5; i++) begin
      step(120 + i, 210, have, e);
      n_total++;
      if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out, pixel_addr} !== '0)
        $display("FAIL reset_state cycle=%0d got h=%0d v=%0d rgb=%h addr=%h exp all zero",
                 i, hcount_out, vcount_out, rgb_out, pixel_addr);
      else n_pass++;
    end
    q.delete();
    lx  = 0;
    ly  = 0;
    rst = 1'b0;
    step(120, 210, have, e);
    n_total++;
    if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out, rgb_out} !== '0)
      $display("FAIL reset_first_edge got h=%0d v=%0d rgb=%h exp all zero", hcount_out, vcount_out, rgb_out);
    else n_pass++;
    for (int h = 121; h < 130; h++) begin
      step(h, 210, have, e);
      n_total++;
      if (!have || {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== e.t)
        $display("FAIL reset_release_timing got %h exp %h", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, e.t);
      else n_pass++;
      n_total++;
      if (rgb_out !== e.r) $display("FAIL reset_release_rgb got %h exp %h", rgb_out, e.r);
      else n_pass++;
    end
  endtask

  task automatic test_rect();
    bit   have;
    exp_t e;
    xpos = 12'd100;
    ypos = 12'd200;
    step(0, 0, have, e);
    for (int v = 196; v < 268; v++) begin
      for (int h = 95; h < 153; h++) begin
        step(h, v, have, e);
        if (have) begin
          n_total++;
          if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== e.t)
            $display("FAIL rect_timing got %h exp %h", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, e.t);
          else n_pass++;
          n_total++;
          if (rgb_out !== e.r) $display("FAIL rect_rgb h=%0d v=%0d got %h exp %h", hcount_out, vcount_out, rgb_out, e.r);
          else n_pass++;
        end
      end
    end
    step(101, 203, have, e);
    n_total++;
    if (pixel_addr !== {6'd3, 6'd1}) $display("FAIL rect_pixel_addr got %h exp %h", pixel_addr, {6'd3, 6'd1});
    else n_pass++;
  endtask

  task automatic test_timing();
    bit   have;
    exp_t e;
    xpos = 12'd100;
    ypos = 12'd200;
    for (int v = 764; v < 780; v++) begin
      for (int h = 0; h < 1344; h++) begin
        step(h, v, have, e);
        if (have) begin
          n_total++;
          if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== e.t)
            $display("FAIL timing_align got %h exp %h", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, e.t);
          else n_pass++;
          n_total++;
          if (rgb_out !== e.r) $display("FAIL timing_rgb h=%0d v=%0d got %h exp %h", hcount_out, vcount_out, rgb_out, e.r);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_right_edge();
    bit   have;
    exp_t e;
    xpos = 12'd1000;
    ypos = 12'd200;
    step(0, 0, have, e);
    for (int v = 210; v < 213; v++) begin
      for (int h = 0; h < 1344; h++) begin
        step(h, v, have, e);
        if (have) begin
          n_total++;
          if ({hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out} !== e.t)
            $display("FAIL edge_timing got %h exp %h", {hcount_out, vcount_out, hsync_out, vsync_out, hblnk_out, vblnk_out}, e.t);
          else n_pass++;
          n_total++;
          if (rgb_out !== e.r) $display("FAIL edge_rgb h=%0d v=%0d got %h exp %h", hcount_out, vcount_out, rgb_out, e.r);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_offscreen();
    bit   have;
    exp_t e;
    xpos = 12'd100;
    ypos = 12'd2040;
    step(0, 0, have, e);
    for (int v = 0; v < 13; v++) begin
      for (int h = 90; h < 161; h++) begin
        step(h, v, have, e);
        if (have) begin
          n_total++;
          if (rgb_out !== e.r) $display("FAIL offscreen_2040_rgb h=%0d v=%0d got %h exp %h", hcount_out, vcount_out, rgb_out, e.r);
          else n_pass++;
        end
      end
    end
    ypos = 12'd800;
    step(0, 0, have, e);
    for (int v = 760; v < 806; v++) begin
      for (int h = 90; h < 161; h++) begin
        step(h, v, have, e);
        if (have) begin
          n_total++;
          if (rgb_out !== e.r) $display("FAIL offscreen_800_rgb h=%0d v=%0d got %h exp %h", hcount_out, vcount_out, rgb_out, e.r);
          else n_pass++;
        end
      end
    end
  endtask

  task automatic test_position_change();
    bit   have;
    exp_t e;
    xpos = 12'd100;
    ypos = 12'd200;
    step(0, 0, have, e);
    for (int pass = 0; pass < 2; pass++) begin
      for (int v = 246; v < 303; v++) begin
        if (v == 255) v = 298;
        if (v == 250) ypos = 12'd300;
        for (int h = 98; h < 151; h++) begin
          step(h, v, have, e);
          if (have) begin
            n_total++;
            if (rgb_out !== e.r) $display("FAIL poschange_rgb pass=%0d h=%0d v=%0d got %h exp %h",
                                          pass, hcount_out, vcount_out, rgb_out, e.r);
            else n_pass++;
          end
        end
      end
      step(0, 0, have, e);
    end
  endtask

  initial begin
    lx = 0;
    ly = 0;
    test_reset();
    test_rect();
    test_timing();
    test_right_edge();
    test_offscreen();
    test_position_change();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
